// File: rtl/ps2_kbd_rx.sv
// ============================================================================
// ps2_kbd_rx
// ----------------------------------------------------------------------------
// PS/2 keyboard host receiver. Synchronizes the PS/2 clock/data pair,
// detects falling clock edges, deserializes 11-bit frames (start, 8 data bits
// LSB first, odd parity, stop), then decodes scan-code set 2 prefixes
// (0xE0 extended, 0xF0 release) into key events. Receive-only.
//
// Optional feature macro: PS2_RX_FILTER_EN
//    When defined, the synchronized PS/2 clock passes through a glitch filter
//    that changes level only after FILTER_LEN consecutive equal samples.
//
// Parameters:
//    TIMEOUT_CYCLES : clk_sys cycles without a PS/2 falling edge before an
//                     in-progress frame is abandoned
//    FILTER_LEN     : glitch filter length (only with PS2_RX_FILTER_EN)
//
// Ports:
//    clk_sys      in  : system clock
//    reset_n      in  : asynchronous active-low reset
//    ps2_kbd_clk  in  : PS/2 clock (asynchronous)
//    ps2_kbd_data in  : PS/2 data (asynchronous)
//    rx_byte      out : last correctly received byte
//    rx_valid     out : one-cycle pulse when rx_byte updates
//    rx_error     out : one-cycle pulse on parity/stop error or timeout
//    key_strobe   out : one-cycle pulse per decoded key event
//    key_code     out : scan code of the event, prefixes stripped
//    key_pressed  out : 1 = make, 0 = break
//    key_extended out : 1 = code was preceded by 0xE0
// ============================================================================
module ps2_kbd_rx #(
   parameter int TIMEOUT_CYCLES = 25000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_kbd_clk,
   input  logic       ps2_kbd_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_error,
   output logic       key_strobe,
   output logic [7:0] key_code,
   output logic       key_pressed,
   output logic       key_extended
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // Two-flop synchronizers. They reset to 1 (idle bus level) so that
   // leaving reset never looks like a falling clock edge.
   logic clk_s1_q, clk_s2_q;
   logic data_s1_q, data_s2_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         data_s1_q <= 1'b1;
         data_s2_q <= 1'b1;
      end else begin
         clk_s1_q  <= ps2_kbd_clk;
         clk_s2_q  <= clk_s1_q;
         data_s1_q <= ps2_kbd_data;
         data_s2_q <= data_s1_q;
      end
   end

   logic clk_f;

`ifdef PS2_RX_FILTER_EN
   localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

   logic             filt_q, filt_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;

   // The counter tracks how many consecutive samples disagree with the
   // current filtered level; any agreeing sample restarts it, so short
   // glitches never reach the edge detector.
   always_comb begin
      filt_d    = filt_q;
      flt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            filt_d = clk_s2_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         filt_q    <= 1'b1;
         flt_cnt_q <= '0;
      end else begin
         filt_q    <= filt_d;
         flt_cnt_q <= flt_cnt_d;
      end
   end

   assign clk_f = filt_q;
`else
   assign clk_f = clk_s2_q;
`endif

   // Falling-edge detector on the (optionally filtered) PS/2 clock.
   logic clk_prev_q;
   logic fall;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_prev_q <= 1'b1;
      end else begin
         clk_prev_q <= clk_f;
      end
   end

   assign fall = clk_prev_q & ~clk_f;

   // Receiver state and registered outputs.
   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            ext_flag_q, ext_flag_d;
   logic            rel_flag_q, rel_flag_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            rx_valid_q, rx_valid_d;
   logic            rx_error_q, rx_error_d;
   logic            key_strobe_q, key_strobe_d;
   logic [7:0]      key_code_q, key_code_d;
   logic            key_pressed_q, key_pressed_d;
   logic            key_extended_q, key_extended_d;
   logic            timeout_hit;

   // A timeout only fires when no edge arrives in the same cycle, so a
   // coinciding falling edge always wins.
   assign timeout_hit = (state_q != ST_IDLE) && !fall &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Next-state, frame assembly and prefix decoding. The odd-parity check
   // requires data plus parity bit to have odd weight.
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      parity_d       = parity_q;
      to_cnt_d       = to_cnt_q;
      ext_flag_d     = ext_flag_q;
      rel_flag_d     = rel_flag_q;
      rx_byte_d      = rx_byte_q;
      rx_valid_d     = 1'b0;
      rx_error_d     = 1'b0;
      key_strobe_d   = 1'b0;
      key_code_d     = key_code_q;
      key_pressed_d  = key_pressed_q;
      key_extended_d = key_extended_q;

      if (state_q == ST_IDLE || fall) begin
         to_cnt_d = '0;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (fall && !data_s2_q) begin
               state_d   = ST_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shift_d = {data_s2_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (fall) begin
               parity_d = data_s2_q;
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               state_d = ST_IDLE;
               if (data_s2_q && (^{shift_q, parity_q})) begin
                  rx_valid_d = 1'b1;
                  rx_byte_d  = shift_q;
                  case (shift_q)
                     8'hE0: ext_flag_d = 1'b1;
                     8'hF0: rel_flag_d = 1'b1;
                     8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
                     end
                     default: begin
                        key_strobe_d   = 1'b1;
                        key_code_d     = shift_q;
                        key_pressed_d  = ~rel_flag_q;
                        key_extended_d = ext_flag_q;
                        ext_flag_d     = 1'b0;
                        rel_flag_d     = 1'b0;
                     end
                  endcase
               end else begin
                  rx_error_d = 1'b1;
                  ext_flag_d = 1'b0;
                  rel_flag_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (timeout_hit) begin
         state_d    = ST_IDLE;
         rx_error_d = 1'b1;
         ext_flag_d = 1'b0;
         rel_flag_d = 1'b0;
         to_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= 3'd0;
         shift_q        <= 8'h00;
         parity_q       <= 1'b0;
         to_cnt_q       <= '0;
         ext_flag_q     <= 1'b0;
         rel_flag_q     <= 1'b0;
         rx_byte_q      <= 8'h00;
         rx_valid_q     <= 1'b0;
         rx_error_q     <= 1'b0;
         key_strobe_q   <= 1'b0;
         key_code_q     <= 8'h00;
         key_pressed_q  <= 1'b0;
         key_extended_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         parity_q       <= parity_d;
         to_cnt_q       <= to_cnt_d;
         ext_flag_q     <= ext_flag_d;
         rel_flag_q     <= rel_flag_d;
         rx_byte_q      <= rx_byte_d;
         rx_valid_q     <= rx_valid_d;
         rx_error_q     <= rx_error_d;
         key_strobe_q   <= key_strobe_d;
         key_code_q     <= key_code_d;
         key_pressed_q  <= key_pressed_d;
         key_extended_q <= key_extended_d;
      end
   end

   assign rx_byte      = rx_byte_q;
   assign rx_valid     = rx_valid_q;
   assign rx_error     = rx_error_q;
   assign key_strobe   = key_strobe_q;
   assign key_code     = key_code_q;
   assign key_pressed  = key_pressed_q;
   assign key_extended = key_extended_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ============================================================================
// tb_ps2_kbd_rx
// ----------------------------------------------------------------------------
// Directed self-checking bench for ps2_kbd_rx. Frames are bit-banged onto the
// PS/2 pins; a monitor counts output pulses and captures the values present
// when each strobe fires.
// ============================================================================
module tb_ps2_kbd_rx;

   localparam int HALF = 20;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_kbd_clk = 1'b1;
   logic       ps2_kbd_data = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_error;
   logic       key_strobe;
   logic [7:0] key_code;
   logic       key_pressed;
   logic       key_extended;

   int checks = 0;
   int errors = 0;

   int         n_valid = 0;
   int         n_error = 0;
   int         n_strobe = 0;
   int         n_overlap = 0;
   int         n_strobe_alone = 0;
   logic [7:0] cap_byte = 8'h00;
   logic [7:0] cap_code = 8'h00;
   logic       cap_pressed = 1'b0;
   logic       cap_ext = 1'b0;

   ps2_kbd_rx dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .ps2_kbd_clk  (ps2_kbd_clk),
      .ps2_kbd_data (ps2_kbd_data),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .rx_error     (rx_error),
      .key_strobe   (key_strobe),
      .key_code     (key_code),
      .key_pressed  (key_pressed),
      .key_extended (key_extended)
   );

   // 100 MHz system clock.
   always #5 clk_sys = ~clk_sys;

   // Pulse monitor, sampled on the falling edge away from DUT updates.
   always @(negedge clk_sys) begin
      if (rx_valid) begin
         n_valid  = n_valid + 1;
         cap_byte = rx_byte;
      end
      if (rx_error) n_error = n_error + 1;
      if (key_strobe) begin
         n_strobe    = n_strobe + 1;
         cap_code    = key_code;
         cap_pressed = key_pressed;
         cap_ext     = key_extended;
         if (!rx_valid) n_strobe_alone = n_strobe_alone + 1;
      end
      if (rx_valid && rx_error) n_overlap = n_overlap + 1;
   end

   task automatic clear_counts();
      n_valid  = 0;
      n_error  = 0;
      n_strobe = 0;
   endtask

   // One PS/2 bit: data changes while clock is high, then a low clock phase.
   task automatic drive_bit(input logic v);
      ps2_kbd_data = v;
      repeat (HALF) @(posedge clk_sys);
      ps2_kbd_clk = 1'b0;
      repeat (HALF) @(posedge clk_sys);
      ps2_kbd_clk = 1'b1;
   endtask

   // Full frame; flip_par inverts the odd-parity bit.
   task automatic applyStimulus(input logic [7:0] b, input logic flip_par);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit((~^b) ^ flip_par);
      drive_bit(1'b1);
      ps2_kbd_data = 1'b1;
      repeat (10) @(posedge clk_sys);
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk_sys);
      checks++; if (rx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_byte got %h exp 00", rx_byte); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid got %b exp 0", rx_valid); end
      checks++; if (rx_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_error got %b exp 0", rx_error); end
      checks++; if (key_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_strobe got %b exp 0", key_strobe); end
      checks++; if (key_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_key_code got %h exp 00", key_code); end
      checks++; if (key_pressed !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_pressed got %b exp 0", key_pressed); end
      checks++; if (key_extended !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_extended got %b exp 0", key_extended); end
      reset_n = 1'b1;
      repeat (5) @(posedge clk_sys);
   endtask

   task automatic test_make();
      clear_counts();
      applyStimulus(8'h1C, 1'b0);
      checks++; if (n_valid !== 1) begin errors++; $display("[TB] FAIL make_valid_count got %0d exp 1", n_valid); end
      checks++; if (cap_byte !== 8'h1C) begin errors++; $display("[TB] FAIL make_rx_byte got %h exp 1c", cap_byte); end
      checks++; if (n_strobe !== 1) begin errors++; $display("[TB] FAIL make_strobe_count got %0d exp 1", n_strobe); end
      checks++; if (cap_code !== 8'h1C) begin errors++; $display("[TB] FAIL make_key_code got %h exp 1c", cap_code); end
      checks++; if (cap_pressed !== 1'b1) begin errors++; $display("[TB] FAIL make_pressed got %b exp 1", cap_pressed); end
      checks++; if (cap_ext !== 1'b0) begin errors++; $display("[TB] FAIL make_extended got %b exp 0", cap_ext); end
   endtask

   task automatic test_extended_break();
      clear_counts();
      applyStimulus(8'hE0, 1'b0);
      applyStimulus(8'hF0, 1'b0);
      applyStimulus(8'h75, 1'b0);
      checks++; if (n_valid !== 3) begin errors++; $display("[TB] FAIL extbrk_valid_count got %0d exp 3", n_valid); end
      checks++; if (n_strobe !== 1) begin errors++; $display("[TB] FAIL extbrk_strobe_count got %0d exp 1", n_strobe); end
      checks++; if (cap_code !== 8'h75) begin errors++; $display("[TB] FAIL extbrk_key_code got %h exp 75", cap_code); end
      checks++; if (cap_pressed !== 1'b0) begin errors++; $display("[TB] FAIL extbrk_pressed got %b exp 0", cap_pressed); end
      checks++; if (cap_ext !== 1'b1) begin errors++; $display("[TB] FAIL extbrk_extended got %b exp 1", cap_ext); end
      applyStimulus(8'h1C, 1'b0);
      checks++; if (n_strobe !== 2) begin errors++; $display("[TB] FAIL extbrk_next_strobe got %0d exp 2", n_strobe); end
      checks++; if (cap_ext !== 1'b0) begin errors++; $display("[TB] FAIL extbrk_next_extended got %b exp 0", cap_ext); end
      checks++; if (cap_pressed !== 1'b1) begin errors++; $display("[TB] FAIL extbrk_next_pressed got %b exp 1", cap_pressed); end
   endtask

   task automatic test_parity_error();
      applyStimulus(8'hAA, 1'b0);
      clear_counts();
      applyStimulus(8'h1C, 1'b1);
      checks++; if (n_error !== 1) begin errors++; $display("[TB] FAIL parity_error_count got %0d exp 1", n_error); end
      checks++; if (n_valid !== 0) begin errors++; $display("[TB] FAIL parity_valid_count got %0d exp 0", n_valid); end
      checks++; if (n_strobe !== 0) begin errors++; $display("[TB] FAIL parity_strobe_count got %0d exp 0", n_strobe); end
      checks++; if (rx_byte !== 8'hAA) begin errors++; $display("[TB] FAIL parity_rx_byte_held got %h exp aa", rx_byte); end
   endtask

   task automatic test_timeout();
      clear_counts();
      applyStimulus(8'hF0, 1'b0);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0]);
      ps2_kbd_data = 1'b1;
      repeat (26000) @(posedge clk_sys);
      checks++; if (n_error !== 1) begin errors++; $display("[TB] FAIL timeout_error_count got %0d exp 1", n_error); end
      checks++; if (n_valid !== 1) begin errors++; $display("[TB] FAIL timeout_valid_count got %0d exp 1", n_valid); end
      applyStimulus(8'h1C, 1'b0);
      checks++; if (n_strobe !== 1) begin errors++; $display("[TB] FAIL timeout_next_strobe got %0d exp 1", n_strobe); end
      checks++; if (cap_pressed !== 1'b1) begin errors++; $display("[TB] FAIL timeout_next_pressed got %b exp 1", cap_pressed); end
      checks++; if (cap_code !== 8'h1C) begin errors++; $display("[TB] FAIL timeout_next_code got %h exp 1c", cap_code); end
   endtask

   task automatic test_glitch();
      clear_counts();
      ps2_kbd_data = 1'b1;
      @(posedge clk_sys);
      ps2_kbd_clk = 1'b0;
      repeat (3) @(posedge clk_sys);
      ps2_kbd_clk = 1'b1;
      repeat (20) @(posedge clk_sys);
      checks++; if (n_valid + n_error + n_strobe !== 0) begin errors++; $display("[TB] FAIL glitch_pulses got %0d exp 0", n_valid + n_error + n_strobe); end
      applyStimulus(8'h4D, 1'b0);
      checks++; if (n_valid !== 1) begin errors++; $display("[TB] FAIL glitch_next_valid got %0d exp 1", n_valid); end
      checks++; if (cap_byte !== 8'h4D) begin errors++; $display("[TB] FAIL glitch_next_byte got %h exp 4d", cap_byte); end
   endtask

   task automatic test_mid_frame_reset();
      int held_bad;
      held_bad = 0;
      clear_counts();
      drive_bit(1'b0);
      for (int i = 0; i < 5; i++) drive_bit(1'b1);
      @(negedge clk_sys);
      reset_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         if ({rx_byte, rx_valid, rx_error, key_strobe, key_code, key_pressed, key_extended} !== 21'd0)
            held_bad = held_bad + 1;
      end
      checks++; if (held_bad !== 0) begin errors++; $display("[TB] FAIL rst_outputs_held_nonzero got %0d exp 0", held_bad); end
      reset_n = 1'b1;
      repeat (10) @(posedge clk_sys);
      checks++; if (n_valid + n_error + n_strobe !== 0) begin errors++; $display("[TB] FAIL rst_partial_pulses got %0d exp 0", n_valid + n_error + n_strobe); end
      applyStimulus(8'hAA, 1'b0);
      checks++; if (n_valid !== 1) begin errors++; $display("[TB] FAIL rst_valid_count got %0d exp 1", n_valid); end
      checks++; if (cap_byte !== 8'hAA) begin errors++; $display("[TB] FAIL rst_rx_byte got %h exp aa", cap_byte); end
      checks++; if (n_strobe !== 0) begin errors++; $display("[TB] FAIL rst_strobe_count got %0d exp 0", n_strobe); end
   endtask

   task automatic test_pulse_rules();
      checks++; if (n_overlap !== 0) begin errors++; $display("[TB] FAIL valid_error_overlap got %0d exp 0", n_overlap); end
      checks++; if (n_strobe_alone !== 0) begin errors++; $display("[TB] FAIL strobe_without_valid got %0d exp 0", n_strobe_alone); end
   endtask

   initial begin
      test_reset();
      test_make();
      test_extended_break();
      test_parity_error();
      test_timeout();
      test_glitch();
      test_mid_frame_reset();
      test_pulse_rules();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard host receiver. Decodes the open-collector `ps2_kbd_clk`/`ps2_kbd_data` pair that the controller-side PS/2 emulation drives into parsed bytes and key events. Key events come out as `key_strobe`/`key_code`/`key_pressed`/`key_extended`. The block sits between the SPI-side PS/2 transmitter and the machine's keyboard matrix logic. It is receive-only and never drives the PS/2 lines.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 25000: number of `clk_sys` cycles without a falling PS/2 clock edge before an in-progress frame is abandoned (1 ms at 25 MHz).
- `FILTER_LEN`, default 8: number of consecutive equal samples required before the filtered PS/2 clock changes. Used only with `PS2_RX_FILTER_EN`.

Ports:
- `clk_sys` in 1: system clock. All logic is on this single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_kbd_clk` in 1: PS/2 clock, asynchronous to `clk_sys`.
- `ps2_kbd_data` in 1: PS/2 data, asynchronous to `clk_sys`.
- `rx_byte` out 8: last correctly received byte.
- `rx_valid` out 1: one-cycle pulse when `rx_byte` updates.
- `rx_error` out 1: one-cycle pulse on a parity error, stop-bit error or timeout.
- `key_strobe` out 1: one-cycle pulse for each decoded key event.
- `key_code` out 8: scan code of the event (set 2, prefixes stripped).
- `key_pressed` out 1: 1 = make, 0 = break.
- `key_extended` out 1: 1 = the code was preceded by 0xE0.

## Operation
- Input path:
  - Both lines pass through a 2-flop synchronizer.
  - A falling edge (`fall`) is detected on the synchronized, and optionally filtered, clock. The data bit is sampled on the same `clk_sys` cycle that `fall` asserts.
- Frame format: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
- FSM states and transitions:
  - IDLE:
    - `fall` with data = 0 → DATA, with `bit_cnt` = 0.
    - `fall` with data = 1 → stay in IDLE silently; no error is flagged.
  - DATA: on each `fall`, shift the data bit into the shift register at bit[7] (right shift).
    - When `bit_cnt` = 7 → PARITY.
    - Otherwise increment `bit_cnt`.
  - PARITY: on `fall`, latch the parity bit → STOP.
  - STOP: on `fall`:
    - If stop bit = 1 and (data XOR parity) has odd weight → accept the byte.
    - Otherwise pulse `rx_error`.
    - Either way → IDLE.
- Timeout:
  - In any state other than IDLE, a counter increments every cycle and clears on `fall`.
  - When it reaches `TIMEOUT_CYCLES` → IDLE, pulse `rx_error`, clear the prefix flags.
- Prefix decoding of accepted bytes:
  - 0xE0 → set `ext_flag`, no `key_strobe`.
  - 0xF0 → set `rel_flag`, no `key_strobe`.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF (controller responses) → no `key_strobe`; flags are unchanged.
  - Any other byte → `key_strobe`, with `key_code` = byte, `key_pressed` = ~`rel_flag`, `key_extended` = `ext_flag`. Both flags then clear.
- Every accepted byte pulses `rx_valid`, whatever decoding does with it.
- `rx_error` clears both prefix flags.
- Reset values: every output 0, FSM in IDLE, flags and counters 0.
- `reset_n` asserted mid-frame discards the partial frame and emits no pulse.

## Timing
- Input latency: about 2 cycles (synchronizer) plus `FILTER_LEN` cycles (filter, if compiled in) from a pin falling edge to `fall`.
- `rx_valid`, `key_strobe` and `rx_error` are registered. They assert on the cycle after the stop-bit (or timeout) condition, for exactly 1 cycle.
- When a key event is produced, `rx_valid` and `key_strobe` assert in the same cycle.
- `rx_byte`, `key_code`, `key_pressed` and `key_extended` update in the same cycle as their strobe and hold until the next strobe.
- Back-to-back frames: a start bit is accepted on the very first `fall` after STOP; no idle gap is required.
- `rx_error` and `rx_valid` never assert in the same cycle.
- A timeout coinciding with `fall` is resolved in favour of `fall`.

## Configuration
- `PS2_RX_FILTER_EN` defined:
  - The synchronized clock passes through a glitch filter. The filtered level changes only after `FILTER_LEN` consecutive equal samples.
  - The filter resets to 1.
- Not defined:
  - `fall` is derived directly from the synchronized clock.
  - `FILTER_LEN` is ignored.
  - Latency drops by `FILTER_LEN` cycles.

## Test plan
- Make code: frame 0x1C (parity 0, stop 1), PS/2 clock ≈ 12.5 kHz → one `rx_valid` with `rx_byte` = 0x1C; one `key_strobe` with `key_code` = 0x1C, `key_pressed` = 1, `key_extended` = 0.
- Extended break: frames E0, F0, 75 → `rx_valid` ×3; a single `key_strobe` on the third byte with `key_code` = 0x75, `key_pressed` = 0, `key_extended` = 1. The next frame 0x1C gives `key_extended` = 0, `key_pressed` = 1.
- Parity error: 0x1C sent with parity 1 → `rx_error` pulses once; no `rx_valid`, no `key_strobe`; `rx_byte` keeps its previous value.
- Timeout: F0 accepted, then clock stopped after 4 data bits for more than 25000 cycles → `rx_error` pulses once. Then a 0x1C frame → `key_pressed` = 1 (the F0 flag was cleared).
- Glitch (with the macro defined): a 3-cycle low pulse on `ps2_kbd_clk` while in IDLE → no state change, no pulses. The same pulse without the macro and with data = 1 → FSM stays in IDLE, no pulses.
- Reset: `reset_n` driven low after 5 data bits, then released, then a full 0xAA frame → `rx_valid` with 0xAA, no `key_strobe`; all outputs were 0 while reset was held.
